sm83_alu_seq: RTL and testbench
===============================

Name: sm83_alu_seq

Overview:
- Micro-sequencer directly upstream of sm83_alu.
- Accepts one 8-bit arithmetic request over a valid/ready handshake and drives the ALU's 3-step control sequence: load A, load B, mux result.
- Captures the ALU result and flags, then returns them on a valid/ready response channel with SM83 Z/N/H/C flag semantics.
- Sits between instruction decode and the register file / flag register.

Parameters:
- DATA_W, 8, operand/result width; only 8 is supported, other values are a synthesis error.

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  3  0=ADD 1=ADC 2=SUB 3=SBC 4=CP 5=INC 6=DEC 7=reserved
- req_a  in  8  operand A
- req_b  in  8  operand B; ignored for INC/DEC
- req_cin  in  1  current C flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_result  out  8  result byte
- rsp_z, rsp_n, rsp_h, rsp_c  out  1 each  new flags
- rsp_wb  out  1  result must be written back (0 for CP)
- alu_op  out  8  ALU operand bus
- alu_load_a, alu_load_b, alu_mux, alu_negate, alu_carry_in  out  1 each  ALU controls
- alu_result  in  8  ALU result
- alu_carry, alu_halfcarry, alu_zero  in  1 each  ALU flag outputs

Behaviour:
- States: IDLE, LD_A, LD_B, EXEC, DONE. Encoding is free.
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All outputs are 0 except req_ready=1.
  - All captured registers are cleared.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready at a clock edge: capture op, a, b and cin, then go to LD_A.
  - An accepted op=7 is treated as ADD.
- LD_A: alu_op=a, alu_load_a=1. Next state LD_B.
- LD_B:
  - alu_op=b for ADD/ADC/SUB/SBC/CP; alu_op=0x01 for INC/DEC.
  - alu_load_b=1.
  - Next state EXEC.
- EXEC:
  - alu_mux=1, alu_op=0.
  - alu_result and flags are registered at the end of this cycle.
  - Next state DONE.
- alu_negate and alu_carry_in are held constant from LD_B through EXEC. In IDLE and LD_A they are 0.
  - alu_negate=1 for SUB, SBC, CP, DEC.
  - alu_carry_in: ADD 0, ADC cin, SUB 1, SBC ~cin, CP 1, INC 0, DEC 1.
- DONE:
  - rsp_valid=1; response fields are stable until the handshake.
  - On rsp_ready: go to IDLE. req_ready stays 0 in DONE.
- Latency: rsp_valid rises 4 cycles after the accept edge. Throughput is one request per 5 cycles at most.
- Flags:
  - rsp_z = alu_zero.
  - rsp_n = 1 for SUB/SBC/CP/DEC, else 0.
  - rsp_h = alu_halfcarry for additive ops; ~alu_halfcarry for negated ops.
  - rsp_c = alu_carry for ADD/ADC; ~alu_carry for SUB/SBC/CP; captured cin for INC/DEC (C is preserved).
- rsp_wb = 0 for CP, 1 otherwise. rsp_result is still the difference for CP.
- Changes on req_* outside the accept edge are ignored. Changes on alu_* outside EXEC are ignored.
- Reset mid-operation: the transaction is abandoned and no response is produced.
- All ALU controls are 0 in IDLE and DONE. This guarantees no spurious load into the ALU.

Optional Feature:
- Macro: SM83_ALU_SEQ_PIPE_EN.
- When defined:
  - req_ready = IDLE | (DONE & rsp_ready).
  - A request accepted in DONE goes straight to LD_A.
  - Back-to-back throughput is one request per 4 cycles.
  - The response of the finished transaction is still handed off on the same edge.
- When undefined: req_ready = IDLE only, and DONE always returns to IDLE.

Test Plan:
- ADD a=0x3A b=0xC6 -> result 0x00, Z1 N0 H1 C1, wb1, rsp_valid exactly 4 cycles after accept.
- SBC a=0x3B b=0x2A cin=1 -> 0x10, Z0 N1 H0 C0; LD_B/EXEC show negate=1, carry_in=0.
- CP a=0x3C b=0x40 -> result 0xFC, wb0, Z0 N1 H0 C1.
- INC a=0xFF cin=1 -> 0x00, Z1 N0 H1 C1 (preserved); DEC a=0x01 cin=0 -> 0x00, Z1 N1 H0 C0.
- Backpressure: hold rsp_ready=0 for 10 cycles after SUB 0x3E-0x3E -> result 0x00 Z1 N1 H0 C0 stays stable; req_ready=0 throughout; a new req_valid is not accepted.
- Assert reset_n=0 during LD_B -> all outputs 0 immediately, req_ready=1 after release, no rsp_valid; with SM83_ALU_SEQ_PIPE_EN, two back-to-back ADDs give accept edges 4 cycles apart.

Source files
------------

// File: rtl/sm83_alu_seq.sv
// sm83_alu_seq: valid/ready micro-sequencer that drives sm83_alu through load-A, load-B, mux.
// Optional macro SM83_ALU_SEQ_PIPE_EN lets DONE accept the next request (4-cycle issue).
module sm83_alu_seq #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_z,
    output logic              rsp_n,
    output logic              rsp_h,
    output logic              rsp_c,
    output logic              rsp_wb,
    output logic [DATA_W-1:0] alu_op,
    output logic              alu_load_a,
    output logic              alu_load_b,
    output logic              alu_mux,
    output logic              alu_negate,
    output logic              alu_carry_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_halfcarry,
    input  logic              alu_zero
);

    if (DATA_W != 8) begin : g_width_check
        $error("sm83_alu_seq supports DATA_W == 8 only");
    end

    typedef enum logic [2:0] {IDLE, LD_A, LD_B, EXEC, DONE} state_e;
    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_SBC = 3'd3,
        OP_CP  = 3'd4, OP_INC = 3'd5, OP_DEC = 3'd6, OP_RSV = 3'd7
    } op_e;

    function automatic logic op_negates(input op_e op);
        return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP) || (op == OP_DEC);
    endfunction

    function automatic logic op_carry_in(input op_e op, input logic cin);
        logic ci;
        case (op)
            OP_ADC:                ci = cin;
            OP_SUB, OP_CP, OP_DEC: ci = 1'b1;
            OP_SBC:                ci = ~cin;
            default:               ci = 1'b0;
        endcase
        return ci;
    endfunction

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              cin_q, cin_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              z_q, z_d, n_q, n_d, h_q, h_d, c_q, c_d, wb_q, wb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] alu_op_q, alu_op_d;
    logic              load_a_q, load_a_d, load_b_q, load_b_d, mux_q, mux_d;
    logic              negate_q, negate_d, carry_in_q, carry_in_d;
    logic              accept;

`ifdef SM83_ALU_SEQ_PIPE_EN
    assign req_ready = (state_q == IDLE) || ((state_q == DONE) && rsp_ready);
`else
    assign req_ready = (state_q == IDLE);
`endif
    assign accept = req_valid && req_ready;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        result_d = result_q;
        z_d      = z_q;
        n_d      = n_q;
        h_d      = h_q;
        c_d      = c_q;
        wb_d     = wb_q;

        if (accept) begin
            op_d  = (op_e'(req_op) == OP_RSV) ? OP_ADD : op_e'(req_op);
            a_d   = req_a;
            b_d   = req_b;
            cin_d = req_cin;
        end

        unique case (state_q)
            IDLE: if (accept) state_d = LD_A;
            LD_A: state_d = LD_B;
            LD_B: state_d = EXEC;
            EXEC: begin
                state_d  = DONE;
                result_d = alu_result;
                z_d      = alu_zero;
                n_d      = op_negates(op_q);
                // the ALU reports carry/half-carry; negated ops need borrow instead
                h_d      = alu_halfcarry ^ op_negates(op_q);
                case (op_q)
                    OP_ADD, OP_ADC:        c_d = alu_carry;
                    OP_SUB, OP_SBC, OP_CP: c_d = ~alu_carry;
                    default:               c_d = cin_q;
                endcase
                wb_d = (op_q != OP_CP);
            end
            DONE: if (rsp_ready) state_d = accept ? LD_A : IDLE;
            default: state_d = IDLE;
        endcase

        // outputs are registered, so decode them from the state being entered
        rsp_valid_d = (state_d == DONE);
        load_a_d    = (state_d == LD_A);
        load_b_d    = (state_d == LD_B);
        mux_d       = (state_d == EXEC);
        negate_d    = ((state_d == LD_B) || (state_d == EXEC)) && op_negates(op_d);
        carry_in_d  = ((state_d == LD_B) || (state_d == EXEC)) && op_carry_in(op_d, cin_d);
        alu_op_d    = '0;
        if (state_d == LD_A) begin
            alu_op_d = a_d;
        end else if (state_d == LD_B) begin
            alu_op_d = ((op_d == OP_INC) || (op_d == OP_DEC)) ? DATA_W'(1) : b_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            result_q    <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            h_q         <= 1'b0;
            c_q         <= 1'b0;
            wb_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            alu_op_q    <= '0;
            load_a_q    <= 1'b0;
            load_b_q    <= 1'b0;
            mux_q       <= 1'b0;
            negate_q    <= 1'b0;
            carry_in_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            result_q    <= result_d;
            z_q         <= z_d;
            n_q         <= n_d;
            h_q         <= h_d;
            c_q         <= c_d;
            wb_q        <= wb_d;
            rsp_valid_q <= rsp_valid_d;
            alu_op_q    <= alu_op_d;
            load_a_q    <= load_a_d;
            load_b_q    <= load_b_d;
            mux_q       <= mux_d;
            negate_q    <= negate_d;
            carry_in_q  <= carry_in_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = result_q;
    assign rsp_z        = z_q;
    assign rsp_n        = n_q;
    assign rsp_h        = h_q;
    assign rsp_c        = c_q;
    assign rsp_wb       = wb_q;
    assign alu_op       = alu_op_q;
    assign alu_load_a   = load_a_q;
    assign alu_load_b   = load_b_q;
    assign alu_mux      = mux_q;
    assign alu_negate   = negate_q;
    assign alu_carry_in = carry_in_q;

endmodule

// File: tb/tb_sm83_alu_seq.sv
// Scoreboard bench for sm83_alu_seq with a behavioural sm83_alu attached to its control bus.
module tb_sm83_alu_seq;

    logic       clk = 1'b0;
    logic       reset_n, req_valid, req_ready, req_cin, rsp_valid, rsp_ready;
    logic [2:0] req_op;
    logic [7:0] req_a, req_b, rsp_result, alu_op, alu_result;
    logic       rsp_z, rsp_n, rsp_h, rsp_c, rsp_wb;
    logic       alu_load_a, alu_load_b, alu_mux, alu_negate, alu_carry_in;
    logic       alu_carry, alu_halfcarry, alu_zero;

    always #5 clk = ~clk;

    sm83_alu_seq #(.DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_h(rsp_h), .rsp_c(rsp_c), .rsp_wb(rsp_wb),
        .alu_op(alu_op), .alu_load_a(alu_load_a), .alu_load_b(alu_load_b),
        .alu_mux(alu_mux), .alu_negate(alu_negate), .alu_carry_in(alu_carry_in),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_halfcarry(alu_halfcarry), .alu_zero(alu_zero)
    );

    typedef struct packed {
        logic [7:0] result;
        logic z, n, h, c, wb;
    } rsp_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a, b;
        logic       cin;
    } txn_t;

    // ALU model: operands latch on load strobes; outputs are noise unless alu_mux is high
    logic [7:0] alu_a_r = '0, alu_b_r = '0, junk = '0, alu_bb;
    logic [2:0] junk_f = '0;
    logic [8:0] alu_sum;
    logic [4:0] alu_hsum;
    always @(posedge clk) begin
        if (alu_load_a) alu_a_r <= alu_op;
        if (alu_load_b) alu_b_r <= alu_op;
    end
    always @(negedge clk) begin
        junk   <= 8'($urandom);
        junk_f <= 3'($urandom);
    end
    always_comb begin
        alu_bb   = alu_negate ? ~alu_b_r : alu_b_r;
        alu_sum  = {1'b0, alu_a_r} + {1'b0, alu_bb} + {8'd0, alu_carry_in};
        alu_hsum = {1'b0, alu_a_r[3:0]} + {1'b0, alu_bb[3:0]} + {4'd0, alu_carry_in};
    end
    assign alu_result    = alu_mux ? alu_sum[7:0] : junk;
    assign alu_carry     = alu_mux ? alu_sum[8] : junk_f[0];
    assign alu_halfcarry = alu_mux ? alu_hsum[4] : junk_f[1];
    assign alu_zero      = alu_mux ? (alu_sum[7:0] == 8'd0) : junk_f[2];

    function automatic rsp_t ref_model(input txn_t t);
        int   a  = int'(t.a);
        int   b  = int'(t.b);
        int   ci = int'(t.cin);
        int   r;
        rsp_t e;
        e.n  = 1'b0;
        e.wb = 1'b1;
        case (t.op)
            3'd1: begin r = a + b + ci; e.h = ((a % 16) + (b % 16) + ci) > 15; e.c = r > 255; end
            3'd2, 3'd4: begin
                r = a - b; e.h = (a % 16) < (b % 16); e.c = a < b; e.n = 1'b1;
                e.wb = (t.op != 3'd4);
            end
            3'd3: begin r = a - b - ci; e.h = (a % 16) < (b % 16) + ci; e.c = a < b + ci; e.n = 1'b1; end
            3'd5: begin r = a + 1; e.h = (a % 16) == 15; e.c = t.cin; end
            3'd6: begin r = a - 1; e.h = (a % 16) == 0; e.c = t.cin; e.n = 1'b1; end
            default: begin r = a + b; e.h = ((a % 16) + (b % 16)) > 15; e.c = r > 255; end
        endcase
        e.result = 8'(r & 255);
        e.z      = (e.result == 8'd0);
        return e;
    endfunction

    // expected {load_a, load_b, mux, negate, carry_in, alu_op} in step ph after acceptance
    function automatic logic [12:0] exp_ctl(input txn_t t, input int ph);
        logic neg, ci;
        neg = (t.op == 3'd2) || (t.op == 3'd3) || (t.op == 3'd4) || (t.op == 3'd6);
        case (t.op)
            3'd1:             ci = t.cin;
            3'd2, 3'd4, 3'd6: ci = 1'b1;
            3'd3:             ci = ~t.cin;
            default:          ci = 1'b0;
        endcase
        case (ph)
            1: return {5'b10000, t.a};
            2: return {3'b010, neg, ci, ((t.op == 3'd5) || (t.op == 3'd6)) ? 8'h01 : t.b};
            3: return {3'b001, neg, ci, 8'h00};
            default: return 13'd0;
        endcase
    endfunction

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [31:0] outs_vec;
    assign outs_vec = {5'd0, rsp_valid, rsp_result, rsp_z, rsp_n, rsp_h, rsp_c, rsp_wb,
                       alu_op, alu_load_a, alu_load_b, alu_mux, alu_negate, alu_carry_in};

    // scoreboard and monitor
    rsp_t sb[$];
    rsp_t last_rsp = '0;
    txn_t cur = '0;
    int   phase = 0, cyc = 0, acc_cyc = 0, prev_acc_cyc = 0, rsp_cnt = 0;
    bit   rsp_seen = 0;

    initial begin
        forever begin
            logic exp_rdy;
            int   nphase;
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                sb.delete();
                phase    = 0;
                rsp_seen = 0;
                continue;
            end
`ifdef SM83_ALU_SEQ_PIPE_EN
            exp_rdy = (phase == 0) || ((phase == 4) && rsp_ready);
`else
            exp_rdy = (phase == 0);
`endif
            chk("alu_ctl", 32'({alu_load_a, alu_load_b, alu_mux, alu_negate, alu_carry_in, alu_op}),
                32'(exp_ctl(cur, phase)));
            chk("rsp_valid", 32'(rsp_valid), 32'(phase == 4));
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: response 0x%0h with empty scoreboard at %0t",
                             rsp_result, $time);
                end else begin
                    chk("rsp_fields", 32'({rsp_result, rsp_z, rsp_n, rsp_h, rsp_c, rsp_wb}), 32'(sb[0]));
                    if (!rsp_seen) chk("latency", 32'(cyc - acc_cyc), 32'd4);
                    rsp_seen = 1;
                    if (rsp_ready) begin
                        last_rsp = sb.pop_front();
                        rsp_cnt++;
                        rsp_seen = 0;
                    end
                end
            end
            nphase = phase;
            if (phase >= 1 && phase <= 3) nphase = phase + 1;
            else if (phase == 4 && rsp_ready) nphase = 0;
            if (req_valid && exp_rdy) begin
                cur          = '{op: req_op, a: req_a, b: req_b, cin: req_cin};
                sb.push_back(ref_model(cur));
                prev_acc_cyc = acc_cyc;
                acc_cyc      = cyc;
                nphase       = 1;
            end
            phase = nphase;
        end
    end

    // response-side backpressure driver
    bit hold_rsp = 0, force_rdy = 0;
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold_rsp ? 1'b0 : (force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0));
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
        bit ok = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: req_ready=0 for 60 cycles, required 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        req_cin   = 1'($urandom);
    endtask

    task automatic wait_rsp(input int tgt);
        for (int i = 0; i < 200 && rsp_cnt < tgt; i++) @(negedge clk);
        chk("rsp_arrived", 32'(rsp_cnt >= tgt), 32'd1);
    endtask

    task automatic directed(input string name, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic cin, input logic [12:0] exp);
        int tgt = rsp_cnt + 1;
        send(op, a, b, cin);
        wait_rsp(tgt);
        chk(name, 32'(last_rsp), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        bit ok;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs_vec, 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        reset_n = 1'b1;

        directed("add_3a_c6", 3'd0, 8'h3A, 8'hC6, 1'b0, {8'h00, 5'b10111});
        directed("sbc_3b_2a", 3'd3, 8'h3B, 8'h2A, 1'b1, {8'h10, 5'b01001});
        directed("cp_3c_40",  3'd4, 8'h3C, 8'h40, 1'b0, {8'hFC, 5'b01010});
        directed("inc_ff",    3'd5, 8'hFF, 8'h55, 1'b1, {8'h00, 5'b10111});
        directed("dec_01",    3'd6, 8'h01, 8'hAA, 1'b0, {8'h00, 5'b11001});
        directed("rsv_as_add", 3'd7, 8'h0F, 8'h01, 1'b1, {8'h10, 5'b00101});

        // stalled response must hold and block new requests
        hold_rsp = 1;
        tgt = rsp_cnt + 1;
        send(3'd2, 8'h3E, 8'h3E, 1'($urandom));
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1;
                break;
            end
        end
        chk("bp_rsp_valid_rise", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 8'h12;
        req_b     = 8'h34;
        repeat (10) @(negedge clk);
        chk("bp_valid_held", 32'(rsp_valid), 32'd1);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_fields_held", 32'({rsp_result, rsp_z, rsp_n, rsp_h, rsp_c, rsp_wb}), 32'({8'h00, 5'b11001}));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        hold_rsp  = 0;
        wait_rsp(tgt);
        chk("bp_sub_3e_3e", 32'(last_rsp), 32'({8'h00, 5'b11001}));

        // reset while in LD_B abandons the transaction
        send(3'd0, 8'($urandom), 8'($urandom), 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_outputs", outs_vec, 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tgt = rsp_cnt;
        repeat (8) @(negedge clk);
        chk("midrst_no_rsp", 32'(rsp_cnt), 32'(tgt));
        chk("midrst_ready_after", 32'(req_ready), 32'd1);

`ifdef SM83_ALU_SEQ_PIPE_EN
        force_rdy = 1;
        tgt = rsp_cnt + 2;
        send(3'd0, 8'h11, 8'h22, 1'b0);
        send(3'd0, 8'h80, 8'h80, 1'b0);
        chk("pipe_accept_gap", 32'(acc_cyc - prev_acc_cyc), 32'd4);
        wait_rsp(tgt);
        chk("pipe_second_add", 32'(last_rsp), 32'({8'h00, 5'b10011}));
        force_rdy = 0;
`endif

        for (int i = 0; i < 60; i++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
